// File: rtl/srl_iter.sv
`default_nettype none
// ============================================================================
// Module      : srl_iter
// Description : Iterative shift-right unit that shifts one bit per cycle.
//               It performs a logical shift, or an arithmetic shift when
//               SRL_ITER_SRA_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module srl_iter #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               arith,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] B,
    output logic [WIDTH-1:0]   Y,
    output logic               busy,
    output logic               done
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               w_accept;
    logic               w_fill;

    assign w_accept = (state_q == S_IDLE) && start;

`ifdef SRL_ITER_SRA_EN
    logic fill_q, fill_d;

    always_comb begin
        fill_d = fill_q;
        if (w_accept) begin
            fill_d = arith & A[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign w_fill = fill_q;
`else
    logic unused_arith;
    assign unused_arith = arith;
    assign w_fill       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (count_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output logic; done is only ever a single-cycle pulse
    always_comb begin
        y_d     = y_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    y_d     = A;
                    count_d = B;
                    busy_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (count_q != '0) begin
                    y_d     = {w_fill, y_q[WIDTH-1:1]};
                    count_d = count_q - SHAMT_W'(1);
                end else begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign Y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_srl_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_srl_iter
// Description : Self-checking bench for srl_iter with a reference shift model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srl_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        arith;
    logic [63:0] A;
    logic [5:0]  B;
    logic [63:0] Y;
    logic        busy;
    logic        done;

    int n_pass;
    int n_total;

    srl_iter #(.WIDTH(64), .SHAMT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .arith (arith),
        .A     (A),
        .B     (B),
        .Y     (Y),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_srl(input logic [63:0] a, input logic [5:0] b, input logic ar);
        logic signed [63:0] s;
        s = a;
`ifdef SRL_ITER_SRA_EN
        if (ar) return s >>> b;
`endif
        return a >> b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Launch one op from the current (post-edge) time; optional stray start at inj_at.
    task automatic run_op(input logic [63:0] a, input logic [5:0] b, input logic ar,
                          input int inj_at, input string tag);
        logic [63:0] exp;
        int          cycles;
        bit          seen;
        exp   = ref_srl(a, b, ar);
        A     = a;
        B     = b;
        arith = ar;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A     = ~a;
        B     = ~b;
        arith = ~ar;
        check({tag, "_busy_on_accept"}, 64'(busy), 64'd1);
        check({tag, "_done_dropped"},   64'(done), 64'd0);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < int'(b) + 6) begin
            if (cycles == inj_at) begin
                start = 1'b1;
                A     = 64'h1234;
                B     = 6'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
            seen = done;
        end
        check({tag, "_latency"}, 64'(cycles), 64'(int'(b) + 1));
        check({tag, "_y"},       Y,           exp);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int  gap;
        bit  seen;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        arith   = 1'b0;
        A       = '0;
        B       = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_y",    Y,          64'd0);
        check("reset_busy", 64'(busy),  64'd0);
        check("reset_done", 64'(done),  64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(64'd1, 6'd0, 1'b0, -1, "b0");
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
        run_op(64'h8000_0000_0000_0000, 6'd63, 1'b0, -1, "b63_logical");
        run_op(64'hF000_0000_0000_0000, 6'd4,  1'b1, -1, "b4_arith");
        run_op(64'h8000_0000_0000_0001, 6'd63, 1'b1, -1, "b63_arith");
        run_op(64'hFF, 6'd4, 1'b0, 2, "ignore_busy_start");

        // Abort an op with reset mid-shift
        @(posedge clk); #1;
        A     = 64'hFFFF;
        B     = 6'd8;
        arith = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_y",    Y,         64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);

        // Start issued in the done cycle must be accepted
        run_op(64'h40, 6'd3, 1'b0, -1, "pre_b2b");
        run_op(64'h10, 6'd2, 1'b0, -1, "b2b");

        for (int i = 0; i < 24; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            run_op({$urandom, $urandom}, 6'($urandom_range(0, 63)),
                   1'($urandom_range(0, 1)), -1, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
